// File: rtl/pulp_cluster_dma_seq32_if.sv
// DMA bundle between the copy sequencer and the ESP DMA engine:
// read/write control requests plus the read and write data channels.
interface pulp_cluster_dma_seq32_if;
    logic        read_ctrl_valid;
    logic        read_ctrl_ready;
    logic [31:0] read_ctrl_data_index;
    logic [31:0] read_ctrl_data_length;
    logic [2:0]  read_ctrl_data_size;
    logic        read_chnl_valid;
    logic        read_chnl_ready;
    logic [31:0] read_chnl_data;
    logic        write_ctrl_valid;
    logic        write_ctrl_ready;
    logic [31:0] write_ctrl_data_index;
    logic [31:0] write_ctrl_data_length;
    logic [2:0]  write_ctrl_data_size;
    logic        write_chnl_valid;
    logic        write_chnl_ready;
    logic [31:0] write_chnl_data;

    modport master (
        output read_ctrl_valid, read_ctrl_data_index, read_ctrl_data_length, read_ctrl_data_size,
        input  read_ctrl_ready,
        input  read_chnl_valid, read_chnl_data,
        output read_chnl_ready,
        output write_ctrl_valid, write_ctrl_data_index, write_ctrl_data_length,
        output write_ctrl_data_size,
        input  write_ctrl_ready,
        output write_chnl_valid, write_chnl_data,
        input  write_chnl_ready
    );

    modport slave (
        input  read_ctrl_valid, read_ctrl_data_index, read_ctrl_data_length, read_ctrl_data_size,
        output read_ctrl_ready,
        output read_chnl_valid, read_chnl_data,
        input  read_chnl_ready,
        input  write_ctrl_valid, write_ctrl_data_index, write_ctrl_data_length,
        input  write_ctrl_data_size,
        output write_ctrl_ready,
        input  write_chnl_valid, write_chnl_data,
        output write_chnl_ready
    );
endinterface

// File: rtl/pulp_cluster_dma_seq32.sv
// Chunked memory-to-memory copy sequencer for the 32-bit ESP DMA port: reads up to CHUNK
// words into a local buffer, writes them back at the destination, repeats until done.
module pulp_cluster_dma_seq32 #(
    parameter int unsigned CHUNK = 16,
    parameter int unsigned CW    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     conf_info_reg1,
    input  logic [31:0]                     conf_info_reg2,
    input  logic [31:0]                     conf_info_reg3,
    input  logic                            conf_done,
    output logic                            acc_done,
    output logic [31:0]                     debug,
    pulp_cluster_dma_seq32_if.master        dma
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdReq  = 3'd1,
        StRdData = 3'd2,
        StWrReq  = 3'd3,
        StWrData = 3'd4,
        StDone   = 3'd5
    } state_e;

    localparam logic [CW:0] One = (CW + 1)'(1);

    state_e      state_q, state_d;
    logic [31:0] src_q, src_d, dst_q, dst_d, rem_q, rem_d;
    logic [CW:0] cur_len_q, cur_len_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0] chunk_cnt_q, chunk_cnt_d;
    logic [31:0] mem_q [CHUNK];
    logic [CW:0] req_len;
    logic        rd_beat;

    assign req_len = (rem_q >= CHUNK) ? (CW + 1)'(CHUNK) : rem_q[CW:0];
    assign rd_beat = (state_q == StRdData) && (wr_ptr_q < cur_len_q) && dma.read_chnl_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            cur_len_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            chunk_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            cur_len_q   <= cur_len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            chunk_cnt_q <= chunk_cnt_d;
        end
    end

    // Staging buffer is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rd_beat && !rst) begin
            mem_q[wr_ptr_q[CW-1:0]] <= dma.read_chnl_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        cur_len_d   = cur_len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        chunk_cnt_d = chunk_cnt_q;

        acc_done                   = 1'b0;
        dma.read_ctrl_valid        = 1'b0;
        dma.read_ctrl_data_index   = '0;
        dma.read_ctrl_data_length  = '0;
        dma.read_ctrl_data_size    = 3'b010;
        dma.read_chnl_ready        = 1'b0;
        dma.write_ctrl_valid       = 1'b0;
        dma.write_ctrl_data_index  = '0;
        dma.write_ctrl_data_length = '0;
        dma.write_ctrl_data_size   = 3'b010;
        dma.write_chnl_valid       = 1'b0;
        dma.write_chnl_data        = '0;

        unique case (state_q)
            StIdle: begin
                if (conf_done) begin
                    src_d       = conf_info_reg1;
                    dst_d       = conf_info_reg2;
                    rem_d       = conf_info_reg3;
                    chunk_cnt_d = '0;
                    state_d     = (conf_info_reg3 == 32'd0) ? StDone : StRdReq;
                end
            end
            StRdReq: begin
                dma.read_ctrl_valid       = 1'b1;
                dma.read_ctrl_data_index  = src_q;
                dma.read_ctrl_data_length = 32'(req_len);
                if (dma.read_ctrl_ready) begin
                    cur_len_d = req_len;
                    wr_ptr_d  = '0;
                    state_d   = StRdData;
                end
            end
            StRdData: begin
                dma.read_chnl_ready = (wr_ptr_q < cur_len_q);
                if (rd_beat) begin
                    wr_ptr_d = wr_ptr_q + One;
                    if (wr_ptr_q + One == cur_len_q) begin
                        state_d = StWrReq;
                    end
                end
            end
            StWrReq: begin
                dma.write_ctrl_valid       = 1'b1;
                dma.write_ctrl_data_index  = dst_q;
                dma.write_ctrl_data_length = 32'(cur_len_q);
                if (dma.write_ctrl_ready) begin
                    rd_ptr_d = '0;
                    state_d  = StWrData;
                end
            end
            StWrData: begin
                dma.write_chnl_valid = 1'b1;
                dma.write_chnl_data  = mem_q[rd_ptr_q[CW-1:0]];
                if (dma.write_chnl_ready) begin
                    rd_ptr_d = rd_ptr_q + One;
                    if (rd_ptr_q == cur_len_q - One) begin
                        src_d       = src_q + 32'(cur_len_q);
                        dst_d       = dst_q + 32'(cur_len_q);
                        rem_d       = rem_q - 32'(cur_len_q);
                        chunk_cnt_d = chunk_cnt_q + 16'd1;
                        state_d     = (rem_q == 32'(cur_len_q)) ? StDone : StRdReq;
                    end
                end
            end
            StDone: begin
                acc_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign debug = {state_q, 13'd0, chunk_cnt_q};

endmodule

// File: tb/tb_pulp_cluster_dma_seq32.sv
// Directed bench for the chunked DMA copy sequencer: a behavioural DMA engine answers the
// requests while a scoreboard of requests and write words predicted from the config is drained.
module tb_pulp_cluster_dma_seq32;
    localparam int unsigned CHUNK = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] reg1, reg2, reg3;
    logic        conf_done;
    logic        acc_done;
    logic [31:0] debug;

    pulp_cluster_dma_seq32_if dma ();

    pulp_cluster_dma_seq32 #(.CHUNK(16), .CW(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .conf_info_reg1 (reg1),
        .conf_info_reg2 (reg2),
        .conf_info_reg3 (reg3),
        .conf_done      (conf_done),
        .acc_done       (acc_done),
        .debug          (debug),
        .dma            (dma)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_rd_q[$];
    logic [63:0] exp_wr_q[$];
    logic [31:0] exp_wd_q[$];

    logic [31:0] data_base = '0, data_salt = '0;
    logic [31:0] rd_idx = '0;
    int          rd_left = 0;
    logic        rv = 1'b0;
    logic        bp = 1'b0;
    logic        conf_pulse = 1'b0;
    logic        restart_arm = 1'b0;
    int          acc_cnt = 0;

    logic        p_rcv = 0, p_rcr = 0, p_wcv = 0, p_wcr = 0, p_wdv = 0, p_wdr = 0, p_rdr = 0;
    logic [31:0] p_rci = 0, p_rcl = 0, p_wci = 0, p_wcl = 0, p_wd = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] src_word(input logic [31:0] idx);
        return (idx - data_base) + 32'd1 + data_salt;
    endfunction

    task automatic push_expect(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        logic [31:0] off, n;
        off = '0;
        while (off < l) begin
            n = (l - off > CHUNK) ? CHUNK : l - off;
            exp_rd_q.push_back({s + off, n});
            exp_wr_q.push_back({d + off, n});
            for (int i = 0; i < int'(n); i++) exp_wd_q.push_back(src_word(s + off + 32'(i)));
            off += n;
        end
    endtask

    task automatic clear_prev();
        p_rcv = 0; p_rcr = 0; p_wcv = 0; p_wcr = 0; p_wdv = 0; p_wdr = 0; p_rdr = 0;
    endtask

    // One clock of the DMA engine model: observe at negedge, then drive the next inputs.
    task automatic tick();
        @(negedge clk);
        if (acc_done) acc_cnt++;
        chk("rd_size", 64'(dma.read_ctrl_data_size), 64'd2);
        chk("wr_size", 64'(dma.write_ctrl_data_size), 64'd2);
        if (!dma.read_ctrl_valid)
            chk("rd_ctrl_idle_zero", {dma.read_ctrl_data_index, dma.read_ctrl_data_length}, 64'd0);
        if (!dma.write_ctrl_valid)
            chk("wr_ctrl_idle_zero", {dma.write_ctrl_data_index, dma.write_ctrl_data_length}, 64'd0);
        if (!dma.write_chnl_valid) chk("wr_data_idle_zero", 64'(dma.write_chnl_data), 64'd0);
        if (p_rcv && !p_rcr) begin
            chk("rd_ctrl_hold_valid", 64'(dma.read_ctrl_valid), 64'd1);
            chk("rd_ctrl_hold", {dma.read_ctrl_data_index, dma.read_ctrl_data_length},
                {p_rci, p_rcl});
        end
        if (p_wcv && !p_wcr) begin
            chk("wr_ctrl_hold_valid", 64'(dma.write_ctrl_valid), 64'd1);
            chk("wr_ctrl_hold", {dma.write_ctrl_data_index, dma.write_ctrl_data_length},
                {p_wci, p_wcl});
        end
        if (p_wdv && !p_wdr)
            chk("wr_data_hold", 64'({dma.write_chnl_valid, dma.write_chnl_data}), 64'({1'b1, p_wd}));

        conf_done  = conf_pulse;
        conf_pulse = 1'b0;
        if (restart_arm && debug[31:29] == 3'd4) begin
            conf_done   = 1'b1;
            reg1        = 32'hDEAD_0000;
            reg2        = 32'hBEEF_0000;
            reg3        = 32'd7;
            restart_arm = 1'b0;
        end
        dma.read_ctrl_ready  = bp ? ($urandom_range(99, 0) >= 40) : 1'b1;
        dma.write_ctrl_ready = bp ? ($urandom_range(99, 0) >= 40) : 1'b1;
        dma.write_chnl_ready = bp ? ($urandom_range(99, 0) >= 40) : 1'b1;
        if (!(rv && !p_rdr)) rv = (rd_left > 0) && (!bp || $urandom_range(99, 0) >= 40);
        dma.read_chnl_valid = rv;
        dma.read_chnl_data  = rv ? src_word(rd_idx) : 32'd0;

        if (dma.read_ctrl_valid && dma.read_ctrl_ready) begin
            chk("rd_req_expected", 64'(exp_rd_q.size() > 0), 64'd1);
            if (exp_rd_q.size() > 0)
                chk("rd_req", {dma.read_ctrl_data_index, dma.read_ctrl_data_length},
                    exp_rd_q.pop_front());
            rd_idx  = dma.read_ctrl_data_index;
            rd_left = int'(dma.read_ctrl_data_length);
        end
        if (rv && dma.read_chnl_ready) begin
            rd_idx++;
            rd_left--;
        end
        if (dma.write_ctrl_valid && dma.write_ctrl_ready) begin
            chk("wr_req_expected", 64'(exp_wr_q.size() > 0), 64'd1);
            if (exp_wr_q.size() > 0)
                chk("wr_req", {dma.write_ctrl_data_index, dma.write_ctrl_data_length},
                    exp_wr_q.pop_front());
        end
        if (dma.write_chnl_valid && dma.write_chnl_ready) begin
            chk("wr_data_expected", 64'(exp_wd_q.size() > 0), 64'd1);
            if (exp_wd_q.size() > 0)
                chk("wr_data", 64'(dma.write_chnl_data), 64'(exp_wd_q.pop_front()));
        end

        p_rcv = dma.read_ctrl_valid;  p_rcr = dma.read_ctrl_ready;
        p_rci = dma.read_ctrl_data_index;  p_rcl = dma.read_ctrl_data_length;
        p_wcv = dma.write_ctrl_valid; p_wcr = dma.write_ctrl_ready;
        p_wci = dma.write_ctrl_data_index; p_wcl = dma.write_ctrl_data_length;
        p_wdv = dma.write_chnl_valid; p_wdr = dma.write_chnl_ready; p_wd = dma.write_chnl_data;
        p_rdr = dma.read_chnl_ready;
    endtask

    task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                         input logic [31:0] salt);
        reg1 = s; reg2 = d; reg3 = l;
        data_base = s;
        data_salt = salt;
        push_expect(s, d, l);
        acc_cnt    = 0;
        conf_pulse = 1'b1;
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                       input logic [31:0] salt, input logic use_bp, input logic restart,
                       input logic [15:0] exp_chunks, output int lat);
        bp          = use_bp;
        restart_arm = restart;
        start(s, d, l, salt);
        lat = 0;
        while (acc_cnt == 0 && lat < 3000) begin
            tick();
            lat++;
        end
        chk("acc_done_seen", 64'(acc_cnt), 64'd1);
        repeat (4) tick();
        chk("acc_done_once", 64'(acc_cnt), 64'd1);
        chk("rd_reqs_left", 64'(exp_rd_q.size()), 64'd0);
        chk("wr_reqs_left", 64'(exp_wr_q.size()), 64'd0);
        chk("wr_data_left", 64'(exp_wd_q.size()), 64'd0);
        chk("chunk_cnt", 64'(debug[15:0]), 64'(exp_chunks));
        chk("state_idle", 64'(debug[31:29]), 64'd0);
    endtask

    initial begin
        int lat;
        int n;
        rst = 1'b1;
        conf_done = 1'b0;
        reg1 = '0; reg2 = '0; reg3 = '0;
        dma.read_ctrl_ready  = 1'b0;
        dma.write_ctrl_ready = 1'b0;
        dma.write_chnl_ready = 1'b0;
        dma.read_chnl_valid  = 1'b0;
        dma.read_chnl_data   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_debug", 64'(debug), 64'd0);
        chk("rst_acc_done", 64'(acc_done), 64'd0);
        chk("rst_valids", 64'({dma.read_ctrl_valid, dma.read_chnl_ready, dma.write_ctrl_valid,
                               dma.write_chnl_valid}), 64'd0);
        chk("rst_outputs_zero", {dma.read_ctrl_data_index, dma.write_chnl_data}, 64'd0);

        run(32'h0, 32'h300, 32'd0, 32'h0, 1'b0, 1'b0, 16'd0, lat);
        chk("len0_latency", 64'(lat), 64'd2);

        run(32'h100, 32'h200, 32'd5, 32'h0, 1'b0, 1'b0, 16'd1, lat);
        run(32'h0, 32'h1000, 32'd40, 32'h5000, 1'b0, 1'b0, 16'd3, lat);
        run(32'h0, 32'h1000, 32'd40, 32'h7000, 1'b1, 1'b0, 16'd3, lat);
        run(32'h0, 32'h1000, 32'd40, 32'h9000, 1'b1, 1'b1, 16'd3, lat);

        // Reset while the second chunk is being read.
        bp = 1'b0;
        start(32'h40, 32'h800, 32'd40, 32'hB000);
        n = 0;
        while (!(debug[31:29] == 3'd2 && debug[15:0] == 16'd1) && n < 500) begin
            tick();
            n++;
        end
        chk("reach_chunk2_rd_data", 64'({debug[31:29], debug[15:0]}), 64'({3'd2, 16'd1}));
        rst = 1'b1;
        clear_prev();
        @(negedge clk);
        chk("mid_rst_valids", 64'({dma.read_ctrl_valid, dma.read_chnl_ready, dma.write_ctrl_valid,
                                   dma.write_chnl_valid, acc_done}), 64'd0);
        chk("mid_rst_debug", 64'(debug), 64'd0);
        rst = 1'b0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_wd_q.delete();
        rd_left = 0;
        rv = 1'b0;
        dma.read_chnl_valid = 1'b0;
        run(32'h20, 32'h600, 32'd3, 32'hC000, 1'b0, 1'b0, 16'd1, lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulp_cluster_dma_seq32.md
Name: pulp_cluster_dma_seq32

Overview:
- Sequencing controller for the pulp_cluster 32-bit ESP DMA interface: performs a chunked memory-to-memory copy driven by the accelerator configuration registers.
- On conf_done, it reads up to CHUNK words via the DMA read channel into a local buffer, then writes them back at the destination index. Repeats until the programmed length is moved, then pulses acc_done.
- Sits between the ESP accelerator socket (conf/DMA ports) and later cluster-side datapaths; replaces the tie-off stub as the first real DMA user.

Parameters:
- CHUNK, 16, max words per DMA burst and local buffer depth; power of two, 2..256.
- CW, 4, log2(CHUNK); buffer pointer width.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- conf_info_reg1  in  32  source word index.
- conf_info_reg2  in  32  destination word index.
- conf_info_reg3  in  32  total length in 32-bit words.
- conf_done  in  1  start request; sampled only in IDLE.
- dma_read_ctrl_valid  out  1  read request valid.
- dma_read_ctrl_ready  in  1  read request accepted.
- dma_read_ctrl_data_index  out  32  read start word index.
- dma_read_ctrl_data_length  out  32  read burst length in words.
- dma_read_ctrl_data_size  out  3  beat size; constant 3'b010 (32-bit).
- dma_read_chnl_valid  in  1  read data valid.
- dma_read_chnl_ready  out  1  read data accept.
- dma_read_chnl_data  in  32  read data.
- dma_write_ctrl_valid  out  1  write request valid.
- dma_write_ctrl_ready  in  1  write request accepted.
- dma_write_ctrl_data_index  out  32  write start word index.
- dma_write_ctrl_data_length  out  32  write burst length in words.
- dma_write_ctrl_data_size  out  3  constant 3'b010.
- dma_write_chnl_valid  out  1  write data valid.
- dma_write_chnl_ready  in  1  write data accept.
- dma_write_chnl_data  out  32  write data.
- acc_done  out  1  one-cycle completion pulse.
- debug  out  32  [31:29] state code, [28:16] zero, [15:0] completed-chunk count.

Behaviour:
- Handshakes: a transfer occurs on a cycle where valid and ready are both high. Valid, once raised, holds with stable data/index/length until accepted. Ready is never a precondition for valid.
- State codes: IDLE=0, RD_REQ=1, RD_DATA=2, WR_REQ=3, WR_DATA=4, DONE=5.
- Registers: src, dst, remaining (32b); cur_len (CW+1 b); wr_ptr, rd_ptr (CW+1 b); chunk_cnt (16b, wraps at 65535).
- IDLE, when conf_done=1:
  - Latch reg1→src, reg2→dst, reg3→remaining; clear chunk_cnt.
  - If reg3==0, go to DONE; else go to RD_REQ.
  - When conf_done=0, stay in IDLE.
- cur_len = min(remaining, CHUNK); it is computed combinationally in RD_REQ and registered on the read ctrl handshake.
- RD_REQ:
  - read_ctrl_valid=1, index=src, length=min(remaining, CHUNK).
  - On handshake: wr_ptr←0 and go to RD_DATA.
- RD_DATA:
  - read_chnl_ready=1 while wr_ptr<cur_len.
  - Each beat stores data to buf[wr_ptr] and increments wr_ptr.
  - On the beat that makes wr_ptr==cur_len, go to WR_REQ.
- WR_REQ:
  - write_ctrl_valid=1, index=dst, length=cur_len.
  - On handshake: rd_ptr←0 and go to WR_DATA.
- WR_DATA:
  - write_chnl_valid=1, write_chnl_data=buf[rd_ptr]; rd_ptr increments per beat.
  - On the last beat (rd_ptr==cur_len−1 accepted):
    - src+=cur_len, dst+=cur_len, remaining−=cur_len, chunk_cnt+=1.
    - Go to DONE if remaining==cur_len, else to RD_REQ.
- DONE: acc_done=1 for exactly one cycle, then go to IDLE.
- Address arithmetic is 32-bit modulo 2^32; index wrap is not checked.
- conf_done outside IDLE is ignored; no queuing.
- Outputs outside their states:
  - read_chnl_ready=0, all other valids=0, acc_done=0.
  - ctrl index/length outputs=0 unless their valid is high.
  - write_chnl_data=0 unless write_chnl_valid is high.
- Reset values: all outputs 0 except the size outputs (3'b010) and debug (0). State=IDLE, all counters 0.
- Buffer contents are not reset.
- rst asserted mid-operation: return to IDLE on the next edge and drop all valids immediately after that edge. The DMA engine is assumed reset together with this block.
- Zero idle cycles between states are allowed; back-to-back beats on every cycle are sustained in both data phases.

Test Plan:
- Length 0: reg3=0, pulse conf_done → no DMA ctrl valid ever; acc_done pulses 2 cycles after conf_done; debug[15:0]=0.
- Single chunk: src=0x100, dst=0x200, len=5, CHUNK=16, data 1..5 → read req (0x100,5), write req (0x200,5), write data 1,2,3,4,5 in order; acc_done once; debug[15:0]=1.
- Multi-chunk: src=0, dst=0x1000, len=40 → read reqs (0,16), (16,16), (32,8); write reqs (0x1000,16), (0x1010,16), (0x1020,8); write data equals read data word-for-word; debug[15:0]=3.
- Backpressure: randomly deassert read_chnl_valid, write_chnl_ready and both ctrl readies (≥30% of cycles) on the len=40 case → identical write stream; ctrl outputs stable while valid and not ready.
- Busy restart: pulse conf_done with new regs during WR_DATA → ignored; original transfer completes unchanged; a single acc_done.
- Reset mid-transfer: assert rst for 1 cycle in RD_DATA of chunk 2 → all valids 0 and debug=0 after the edge; a new conf_done (len=3) runs correctly from scratch.
